bank_frame_reader: RTL and testbench

Read-side controller for one packet-buffer SRAM bank in the 4-port switch. Accepts a frame descriptor (start word address, length in words), issues one-word-per-cycle reads to the bank's read port, absorbs the bank's 1-cycle read latency, and presents the frame as a valid/ready word stream with end-of-frame marking to the egress port logic. Sits between the bank SRAM read port and the per-port transmit path.

---
 rtl/switch_bank_pkg.sv | 19 +
 rtl/bank_rd_fifo.sv | 49 ++++
 rtl/bank_frame_reader.sv | 114 +++++++++++
 tb/tb_bank_frame_reader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_bank_pkg.sv
// Shared definitions for the packet-buffer bank controllers: geometry, read FSM
// states and the wrapping address increment used by both read and write sides.
package switch_bank_pkg;

  localparam int DEPTH  = 4608;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  // Bank depth is not a power of two, so the wrap has to be explicit.
  function automatic int unsigned addr_inc(input int unsigned addr, input int unsigned depth);
    return (addr == depth - 1) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/bank_rd_fifo.sv
// Three-entry synchronous FIFO holding {last, data} words returned by the bank,
// with an occupancy count used by the read issue logic.
module bank_rd_fifo #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [3];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign do_push = push && (count != 2'd3);
  assign do_pop  = pop && (count != 2'd0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 2'd0;
      for (int i = 0; i < 3; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bank_frame_reader.sv
// Read-side controller for one SRAM bank: turns a {addr, len} descriptor into
// paced bank reads and a valid/ready word stream with end-of-frame marking.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid never depends on ready, and data/last hold while valid & !ready.
module bank_frame_reader
  import switch_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = switch_bank_pkg::DEPTH,
  parameter int LEN_WIDTH  = 9
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_desc_valid,
  output logic                     o_desc_ready,
  input  logic [$clog2(DEPTH)-1:0] i_desc_addr,
  input  logic [LEN_WIDTH-1:0]     i_desc_len,
  output logic                     o_mem_read,
  output logic [$clog2(DEPTH)-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0]    i_mem_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic                     o_last,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err,
  output rd_state_t                o_state
);

  localparam int AW = $clog2(DEPTH);

  rd_state_t            state;
  rd_state_t            state_nxt;
  logic [AW-1:0]        addr;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 inflight;
  logic                 inflight_last;
  logic                 done;
  logic                 err;
  logic [1:0]           fifo_count;
  logic                 issue;
  logic                 desc_fire;
  logic                 desc_start;
  logic                 out_fire;
  logic                 last_fire;
  logic                 issue_last;

  // Issue only from registered occupancy so downstream ready never reaches the bank.
  assign issue      = (state == READ) && ((3'(fifo_count) + 3'(inflight)) < 3'd3);
  assign issue_last = issue && (remaining == LEN_WIDTH'(1));
  assign desc_fire  = (state == IDLE) && i_desc_valid;
  assign desc_start = desc_fire && (i_desc_len != '0);
  assign out_fire   = o_valid && i_ready;
  assign last_fire  = out_fire && o_last;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (desc_start) state_nxt = READ;
      READ:    if (issue_last) state_nxt = DRAIN;
      DRAIN:   if (last_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      addr          <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_nxt;
      inflight      <= issue;
      inflight_last <= issue_last;
      done          <= (state == DRAIN) && last_fire;
      err           <= desc_fire && (i_desc_len == '0);
      if (desc_start) begin
        addr      <= i_desc_addr;
        remaining <= i_desc_len;
      end else if (issue) begin
        addr      <= AW'(addr_inc(32'(addr), DEPTH));
        remaining <= remaining - LEN_WIDTH'(1);
      end
    end
  end

  bank_rd_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (inflight),
    .wdata ({inflight_last, i_mem_data}),
    .pop   (out_fire),
    .rdata ({o_last, o_data}),
    .count (fifo_count)
  );

  assign o_valid      = (fifo_count != 2'd0);
  assign o_mem_read   = issue;
  assign o_mem_addr   = addr;
  assign o_desc_ready = (state == IDLE);
  assign o_busy       = (state != IDLE);
  assign o_done       = done;
  assign o_err        = err;
  assign o_state      = state;

endmodule

// File: tb/tb_bank_frame_reader.sv
// Directed bench for bank_frame_reader with a bank model, read-address and
// output-word scoreboards, and cycle-exact checks on the key timing points.
module tb_bank_frame_reader;
  import switch_bank_pkg::*;

  localparam int DW = 32;
  localparam int AW = 13;
  localparam int LW = 9;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_desc_valid;
  logic          o_desc_ready;
  logic [AW-1:0] i_desc_addr;
  logic [LW-1:0] i_desc_len;
  logic          o_mem_read;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] i_mem_data;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic          o_last;
  logic          o_busy;
  logic          o_done;
  logic          o_err;
  rd_state_t     o_state;

  int errors = 0;
  int checks = 0;
  int occ = 0;
  int words_seen = 0;
  logic [DW:0]   exp_q[$];
  logic [AW-1:0] addr_q[$];

  bank_frame_reader dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_desc_valid (i_desc_valid),
    .o_desc_ready (o_desc_ready),
    .i_desc_addr  (i_desc_addr),
    .i_desc_len   (i_desc_len),
    .o_mem_read   (o_mem_read),
    .o_mem_addr   (o_mem_addr),
    .i_mem_data   (i_mem_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_last       (o_last),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_state      (o_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {3'b101, a, 3'b011, a};
  endfunction

  // bank model: one-cycle read latency
  always @(posedge i_clk) begin
    if (o_mem_read) i_mem_data <= mem_word(o_mem_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge i_clk) begin
    logic [DW:0]   exp_w;
    logic [AW-1:0] exp_a;
    if (!i_rst_n) begin
      occ = 0;
    end else begin
      if (o_mem_read) begin
        check("occupancy_room", 64'(occ < 3), 64'd1);
        exp_a = (addr_q.size() != 0) ? addr_q.pop_front() : 'x;
        check("read_addr", 64'(o_mem_addr), 64'(exp_a));
      end
      if (o_valid && i_ready) begin
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check("out_word", 64'({o_last, o_data}), 64'(exp_w));
        words_seen++;
      end
      occ = occ + int'(o_mem_read) - int'(o_valid && i_ready);
    end
  end

  // driver tasks
  task automatic push_frame(input logic [AW-1:0] a, input logic [LW-1:0] n);
    logic [AW-1:0] ad;
    ad = a;
    for (int i = 0; i < int'(n); i++) begin
      addr_q.push_back(ad);
      exp_q.push_back({(i == int'(n) - 1), mem_word(ad)});
      ad = (ad == AW'(DEPTH - 1)) ? '0 : ad + 1'b1;
    end
  endtask

  // Returns one step after the handshake edge (cycle T+1).
  task automatic send_desc(input logic [AW-1:0] a, input logic [LW-1:0] n, input bit keep);
    int k;
    i_desc_valid = 1'b1;
    i_desc_addr  = a;
    i_desc_len   = n;
    k = 0;
    @(negedge i_clk);
    while (!o_desc_ready && k < 100) begin
      @(negedge i_clk);
      k++;
    end
    check("desc_accept_timeout", 64'(k < 100), 64'd1);
    push_frame(a, n);
    @(posedge i_clk);
    #1;
    if (!keep) i_desc_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge i_clk);
      k++;
    end while ((exp_q.size() != 0 || o_busy) && k < 300);
    check("idle_timeout", 64'(k < 300), 64'd1);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int w0;
    int k;
    logic [DW:0] held;
    i_rst_n      = 1'b0;
    i_desc_valid = 1'b0;
    i_desc_addr  = '0;
    i_desc_len   = '0;
    i_ready      = 1'b1;
    i_mem_data   = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_outputs", 64'({o_mem_read, o_mem_addr, o_valid, o_data, o_last, o_busy, o_done, o_err}), 64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("reset_ready", 64'({o_desc_ready, o_state}), 64'({1'b1, IDLE}));
    @(posedge i_clk);
    #1;

    // basic frame with cycle-exact timing
    send_desc(13'd10, 9'd4, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge i_clk);
      check($sformatf("t1_read_c%0d", c), 64'(o_mem_read), 64'(c <= 4));
      check($sformatf("t1_valid_c%0d", c), 64'(o_valid), 64'(c >= 3 && c <= 6));
      check($sformatf("t1_last_c%0d", c), 64'(o_last && o_valid), 64'(c == 6));
      check($sformatf("t1_done_c%0d", c), 64'(o_done), 64'(c == 7));
      check($sformatf("t1_dready_c%0d", c), 64'(o_desc_ready), 64'(c >= 7));
      @(posedge i_clk);
      #1;
    end

    // address wrap at the top of the bank
    send_desc(13'd4606, 9'd4, 1'b0);
    wait_idle();

    // backpressure after word 2
    w0 = words_seen;
    send_desc(13'd500, 9'd8, 1'b0);
    k = 0;
    while (words_seen - w0 < 2 && k < 50) begin
      @(posedge i_clk);
      #1;
      k++;
    end
    check("bp_wait_timeout", 64'(k < 50), 64'd1);
    i_ready = 1'b0;
    held = '0;
    for (int s = 1; s <= 5; s++) begin
      @(negedge i_clk);
      check("bp_valid_held", 64'(o_valid), 64'd1);
      if (s == 1) begin
        held = {o_last, o_data};
        check("bp_head", 64'(held), 64'({1'b0, mem_word(13'd502)}));
      end else begin
        check("bp_stable", 64'({o_last, o_data}), 64'(held));
      end
      if (s >= 3) check("bp_no_read", 64'(o_mem_read), 64'd0);
      @(posedge i_clk);
      #1;
    end
    i_ready = 1'b1;
    wait_idle();
    check("bp_word_count", 64'(words_seen - w0), 64'd8);

    // zero-length descriptor is rejected
    send_desc(13'd77, 9'd0, 1'b0);
    @(negedge i_clk);
    check("len0_err", 64'({o_err, o_desc_ready, o_mem_read, o_busy}), 64'b1100);
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    check("len0_err_pulse", 64'({o_err, o_mem_read}), 64'b00);
    @(posedge i_clk);
    #1;

    // single-word frame
    send_desc(13'd33, 9'd1, 1'b0);
    wait_idle();

    // back-to-back descriptors held valid
    send_desc(13'd200, 9'd3, 1'b1);
    i_desc_addr = 13'd300;
    i_desc_len  = 9'd2;
    k = 0;
    do begin
      @(negedge i_clk);
      k++;
    end while (!o_desc_ready && k < 50);
    check("b2b_accept_cycle", 64'(k), 64'd6);
    check("b2b_done_at_accept", 64'(o_done), 64'd1);
    push_frame(13'd300, 9'd2);
    @(posedge i_clk);
    #1;
    i_desc_valid = 1'b0;
    wait_idle();

    // asynchronous reset mid-frame
    w0 = words_seen;
    send_desc(13'd50, 9'd6, 1'b0);
    k = 0;
    while (words_seen - w0 < 2 && k < 50) begin
      @(posedge i_clk);
      #1;
      k++;
    end
    check("rst_wait_timeout", 64'(k < 50), 64'd1);
    i_rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", 64'({o_mem_read, o_mem_addr, o_valid, o_data, o_last, o_busy, o_done, o_err}), 64'd0);
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst_release_ready", 64'({o_desc_ready, o_busy}), 64'b10);
    @(posedge i_clk);
    #1;
    send_desc(13'd100, 9'd2, 1'b0);
    wait_idle();

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("addr_q_drained", 64'(addr_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
